// File: rtl/vga_pixel_sink.sv
// vga_pixel_sink: stores plotted pixels in a 3-bit framebuffer and scans it out as VGA,
// each stored pixel shown as a 2x2 block. A clear sweep fills the buffer after every reset.
module vga_pixel_sink #(
  parameter int unsigned X_PIXELS   = 320,
  parameter int unsigned Y_PIXELS   = 240,
  parameter logic [2:0]  BACKGROUND = 3'b000,
  parameter int unsigned H_VIS      = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_VIS      = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33
) (
  input  logic       iClock,
  input  logic       iReset,
  input  logic [8:0] iX,
  input  logic [7:0] iY,
  input  logic [2:0] iColour,
  input  logic       iPlot,
  output logic       oBusy,
  output logic       oVGA_CLK,
  output logic       oVGA_HS,
  output logic       oVGA_VS,
  output logic       oVGA_BLANK_N,
  output logic       oVGA_SYNC_N,
  output logic [7:0] oVGA_R,
  output logic [7:0] oVGA_G,
  output logic [7:0] oVGA_B
);

  localparam int unsigned FbWords    = X_PIXELS * Y_PIXELS;
  localparam logic [16:0] LastAddr   = 17'(FbWords - 1);
  localparam logic [16:0] XStride    = 17'(X_PIXELS);
  localparam logic [8:0]  XLim       = 9'(X_PIXELS);
  localparam logic [7:0]  YLim       = 8'(Y_PIXELS);
  localparam logic [9:0]  HVis       = 10'(H_VIS);
  localparam logic [9:0]  HSyncStart = 10'(H_VIS + H_FP);
  localparam logic [9:0]  HSyncEnd   = 10'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [9:0]  HLast      = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0]  VVis       = 10'(V_VIS);
  localparam logic [9:0]  VSyncStart = 10'(V_VIS + V_FP);
  localparam logic [9:0]  VSyncEnd   = 10'(V_VIS + V_FP + V_SYNC - 1);
  localparam logic [9:0]  VLast      = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);

  typedef enum logic [0:0] {StClear, StRun} wr_state_e;

  wr_state_e   state_q, state_d;
  logic [16:0] clr_addr_q, clr_addr_d;
  logic        wr_en;
  logic [16:0] wr_addr;
  logic [2:0]  wr_data;
  logic [16:0] plot_addr;
  logic        plot_ok;

  logic        tick_q;
  logic        tick_en;
  logic [9:0]  hcount_q, vcount_q;
  logic        hs_raw, vs_raw, vis_raw;
  logic        hs_q, vs_q, vis_q;
  logic [16:0] rd_addr;
  logic        rd_en;
  logic [2:0]  rd_data_q;

  logic [2:0]  fb_mem [FbWords];

  assign plot_addr = 17'(iY) * XStride + 17'(iX);
  assign plot_ok   = iPlot && (iX < XLim) && (iY < YLim);

  // Write FSM state and clear-sweep address.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      state_q    <= StClear;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  // Write FSM: sweep BACKGROUND over the whole buffer, then accept in-range plots.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    wr_en      = 1'b0;
    wr_addr    = plot_addr;
    wr_data    = iColour;
    oBusy      = 1'b0;
    unique case (state_q)
      StClear: begin
        oBusy      = 1'b1;
        wr_en      = 1'b1;
        wr_addr    = clr_addr_q;
        wr_data    = BACKGROUND;
        clr_addr_d = clr_addr_q + 17'd1;
        if (clr_addr_q == LastAddr) begin
          state_d = StRun;
        end
      end
      StRun: begin
        wr_en = plot_ok;
      end
    endcase
  end

  // Pixel tick: enable on every second clock, the exported pixel clock follows the toggle.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      tick_q <= 1'b0;
    end else begin
      tick_q <= ~tick_q;
    end
  end

  assign tick_en = ~tick_q;

  // Raster counters, advanced once per pixel tick.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      hcount_q <= '0;
      vcount_q <= '0;
    end else if (tick_en) begin
      if (hcount_q == HLast) begin
        hcount_q <= '0;
        vcount_q <= (vcount_q == VLast) ? 10'd0 : vcount_q + 10'd1;
      end else begin
        hcount_q <= hcount_q + 10'd1;
      end
    end
  end

  assign hs_raw  = !((hcount_q >= HSyncStart) && (hcount_q <= HSyncEnd));
  assign vs_raw  = !((vcount_q >= VSyncStart) && (vcount_q <= VSyncEnd));
  assign vis_raw = (hcount_q < HVis) && (vcount_q < VVis);
  assign rd_addr = 17'(vcount_q[9:1]) * XStride + 17'(hcount_q[9:1]);
  assign rd_en   = tick_en && vis_raw;

  // Framebuffer: one write port, one synchronous read port; a same-cycle read sees old data.
  always_ff @(posedge iClock) begin
    if (wr_en && !iReset) begin
      fb_mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data_q <= fb_mem[rd_addr];
    end
  end

  // Delay sync and visible by one tick so they line up with the RAM read data.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      vis_q <= 1'b0;
    end else if (tick_en) begin
      hs_q  <= hs_raw;
      vs_q  <= vs_raw;
      vis_q <= vis_raw;
    end
  end

  assign oVGA_CLK     = tick_q;
  assign oVGA_HS      = hs_q;
  assign oVGA_VS      = vs_q;
  assign oVGA_BLANK_N = vis_q;
  assign oVGA_SYNC_N  = 1'b0;
  assign oVGA_R       = vis_q ? {8{rd_data_q[2]}} : 8'h00;
  assign oVGA_G       = vis_q ? {8{rd_data_q[1]}} : 8'h00;
  assign oVGA_B       = vis_q ? {8{rd_data_q[0]}} : 8'h00;

endmodule

// File: tb/tb_vga_pixel_sink.sv
// Bench for vga_pixel_sink on a scaled-down raster: a pixel-index model predicts every output
// each clock, with random and directed plots applied to a model framebuffer.
module tb_vga_pixel_sink;

  localparam int XP     = 16;
  localparam int YP     = 12;
  localparam int HV     = 32;
  localparam int HF     = 4;
  localparam int HSW    = 6;
  localparam int HB     = 6;
  localparam int VV     = 24;
  localparam int VF     = 2;
  localparam int VSW    = 2;
  localparam int VB     = 3;
  localparam int HT     = HV + HF + HSW + HB;
  localparam int VT     = VV + VF + VSW + VB;
  localparam int NW     = XP * YP;
  localparam logic [2:0] BG = 3'b010;

  logic       iClock = 1'b0;
  logic       iReset;
  logic [8:0] iX;
  logic [7:0] iY;
  logic [2:0] iColour;
  logic       iPlot;
  logic       oBusy, oVGA_CLK, oVGA_HS, oVGA_VS, oVGA_BLANK_N, oVGA_SYNC_N;
  logic [7:0] oVGA_R, oVGA_G, oVGA_B;

  always #5 iClock = ~iClock;

  vga_pixel_sink #(
    .X_PIXELS  (XP),
    .Y_PIXELS  (YP),
    .BACKGROUND(BG),
    .H_VIS     (HV),
    .H_FP      (HF),
    .H_SYNC    (HSW),
    .H_BP      (HB),
    .V_VIS     (VV),
    .V_FP      (VF),
    .V_SYNC    (VSW),
    .V_BP      (VB)
  ) dut (
    .iClock      (iClock),
    .iReset      (iReset),
    .iX          (iX),
    .iY          (iY),
    .iColour     (iColour),
    .iPlot       (iPlot),
    .oBusy       (oBusy),
    .oVGA_CLK    (oVGA_CLK),
    .oVGA_HS     (oVGA_HS),
    .oVGA_VS     (oVGA_VS),
    .oVGA_BLANK_N(oVGA_BLANK_N),
    .oVGA_SYNC_N (oVGA_SYNC_N),
    .oVGA_R      (oVGA_R),
    .oVGA_G      (oVGA_G),
    .oVGA_B      (oVGA_B)
  );

  // Model state: fb holds -1 where the content is not yet known.
  int   fb [NW];
  int   n, c, p, exp_col, cyc;
  logic exp_hs, exp_vs, exp_vis;
  int   n_checks, n_pass, n_fail;
  bit   stats_on;
  int   blank_cnt, hs_low, vs_low, blank_rgb;
  int   fall;

  function automatic logic [23:0] rgb_of(input int col);
    logic [2:0] c3;
    c3 = col[2:0];
    return {{8{c3[2]}}, {8{c3[1]}}, {8{c3[0]}}};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s at cycle %0d: observed %0h, expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs presented at that edge.
  task automatic model_edge();
    int h, v;
    if (iReset) begin
      n = 0; c = 0;
      exp_hs = 1'b1; exp_vs = 1'b1; exp_vis = 1'b0; exp_col = 0;
    end else begin
      n++;
      if (n % 2 == 1) begin
        p = (n - 1) / 2;
        h = p % HT;
        v = (p / HT) % VT;
        exp_hs  = !(h >= HV + HF && h < HV + HF + HSW);
        exp_vs  = !(v >= VV + VF && v < VV + VF + VSW);
        exp_vis = (h < HV) && (v < VV);
        exp_col = exp_vis ? fb[(v / 2) * XP + h / 2] : 0;
      end
      if (c < NW) begin
        fb[c] = int'(BG);
        c++;
      end else if (iPlot && int'(iX) < XP && int'(iY) < YP) begin
        fb[int'(iY) * XP + int'(iX)] = int'(iColour);
      end
    end
  endtask

  task automatic compare_all();
    logic [23:0] rgb;
    rgb = {oVGA_R, oVGA_G, oVGA_B};
    check("busy", 32'(oBusy), 32'(c < NW));
    check("vga_clk", 32'(oVGA_CLK), 32'(n % 2 == 1));
    check("hsync", 32'(oVGA_HS), 32'(exp_hs));
    check("vsync", 32'(oVGA_VS), 32'(exp_vs));
    check("blank_n", 32'(oVGA_BLANK_N), 32'(exp_vis));
    check("sync_n", 32'(oVGA_SYNC_N), 32'(1'b0));
    if (!exp_vis || exp_col >= 0) begin
      check("rgb", 32'(rgb), 32'(exp_vis ? rgb_of(exp_col) : 24'h0));
    end
    if (stats_on && n % 2 == 1 && p >= HT * VT && p < 2 * HT * VT) begin
      blank_cnt += int'(oVGA_BLANK_N);
      hs_low    += int'(!oVGA_HS);
      vs_low    += int'(!oVGA_VS);
      if (!oVGA_BLANK_N && rgb != 24'h0) blank_rgb++;
    end
  endtask

  task automatic cycle();
    @(posedge iClock);
    model_edge();
    #1;
    cyc++;
    compare_all();
  endtask

  task automatic plot(input int x, input int y, input int col);
    iPlot   = 1'b1;
    iX      = 9'(x);
    iY      = 8'(y);
    iColour = 3'(col);
    cycle();
    iPlot   = 1'b0;
  endtask

  initial begin
    n_checks = 0; n_pass = 0; n_fail = 0; cyc = 0;
    stats_on = 1'b0; blank_cnt = 0; hs_low = 0; vs_low = 0; blank_rgb = 0;
    n = 0; c = 0; p = 0; exp_col = 0;
    exp_hs = 1'b1; exp_vs = 1'b1; exp_vis = 1'b0;
    for (int i = 0; i < NW; i++) fb[i] = -1;
    iReset = 1'b1; iPlot = 1'b0; iX = '0; iY = '0; iColour = '0;

    // Reset held for three cycles.
    repeat (3) cycle();
    iReset = 1'b0;

    // Clear sweep with random plots that must all be dropped; (5,5) lands after its clear.
    fall = -1;
    for (int i = 0; i < NW + 20; i++) begin
      iPlot   = ($urandom_range(0, 1) == 1);
      iX      = 9'($urandom_range(0, XP - 1));
      iY      = 8'($urandom_range(0, YP - 1));
      iColour = 3'($urandom_range(1, 7));
      if (i == 150) begin
        iPlot = 1'b1; iX = 9'd5; iY = 8'd5; iColour = 3'b111;
      end
      cycle();
      if (fall < 0 && oBusy == 1'b0) fall = n;
    end
    iPlot = 1'b0;
    check("busy_length", 32'(fall), 32'(NW));

    // Random plots away from the corner rows, some out of range.
    for (int i = 0; i < 300; i++) begin
      iPlot   = ($urandom_range(0, 3) != 0);
      iX      = 9'($urandom_range(0, XP + 3));
      iY      = ($urandom_range(0, 7) == 0) ? 8'(YP + $urandom_range(0, 3))
                                            : 8'($urandom_range(2, YP - 3));
      iColour = 3'($urandom_range(0, 7));
      cycle();
    end
    iPlot = 1'b0;

    // Corner plots and out-of-range plots that must leave the buffer untouched.
    plot(0, 0, 3'b110);
    plot(XP - 1, YP - 1, 3'b001);
    plot(XP, 10, 3'b111);
    plot(10, YP, 3'b111);
    plot(511, 255, 3'b101);

    // Idle through the whole of the second frame, gathering timing statistics.
    stats_on = 1'b1;
    for (int i = 0; i < 8000 && n < 4 * HT * VT + 1; i++) cycle();
    stats_on = 1'b0;
    check("blank_ticks", 32'(blank_cnt), 32'(HV * VV));
    check("hs_low_ticks", 32'(hs_low), 32'(HSW * VT));
    check("vs_low_ticks", 32'(vs_low), 32'(VSW * HT));
    check("rgb_in_blank", 32'(blank_rgb), 32'(0));

    // Reset mid-frame while scanning; the sweep restarts and the screen returns to background.
    repeat (700) cycle();
    check("busy_before_reset", 32'(oBusy), 32'(1'b0));
    iReset = 1'b1;
    cycle();
    check("midreset_busy", 32'(oBusy), 32'(1'b1));
    check("midreset_hs", 32'(oVGA_HS), 32'(1'b1));
    check("midreset_vs", 32'(oVGA_VS), 32'(1'b1));
    iReset = 1'b0;
    repeat (NW + 2 * HT * VT + 16) cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
